// File: rtl/maze_scanner_pkg.sv
// Shared constants, state encoding and extent helper for the maze scanner.
package maze_pkg;

  localparam int MAZE_W  = 64;
  localparam int MAZE_H  = 64;
  localparam int BLOCK   = 8;
  localparam int COORD_W = 6;
  localparam int COUNT_W = 13;
  localparam int IDX_W   = 12;
  localparam int DIM_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Number of cells along one axis for a 3-bit dimension select (8..64).
  function automatic logic [COORD_W:0] active_extent(input logic [DIM_W-1:0] dim);
    active_extent = (COORD_W+1)'(BLOCK) * ((COORD_W+1)'(dim) + 7'd1);
  endfunction

endpackage

// File: rtl/maze_scanner_if.sv
// Bitmap input plus cell stream of the maze scanner.
// master: the scanner (consumes the bitmap, drives the cell stream).
// slave : the environment (carver + renderer/collision side).
interface maze_scanner_if;
  import maze_pkg::*;

  logic                        maze_finish;
  logic [MAZE_W*MAZE_H-1:0]    maze_data;
  logic [DIM_W-1:0]            x_dimension;
  logic [DIM_W-1:0]            y_dimension;
  logic                        cell_ready;
  logic                        cell_valid;
  logic                        cell_wall;
  logic [COORD_W-1:0]          cell_x;
  logic [COORD_W-1:0]          cell_y;
  logic                        cell_last;
  logic                        busy;
  logic                        scan_done;
  logic [COUNT_W-1:0]          wall_count;

  modport master (
    input  maze_finish, maze_data, x_dimension, y_dimension, cell_ready,
    output cell_valid, cell_wall, cell_x, cell_y, cell_last, busy, scan_done, wall_count
  );

  modport slave (
    output maze_finish, maze_data, x_dimension, y_dimension, cell_ready,
    input  cell_valid, cell_wall, cell_x, cell_y, cell_last, busy, scan_done, wall_count
  );
endinterface

// File: rtl/maze_scanner.sv
// Snapshots a finished maze bitmap and streams the active region row-major,
// one cell per valid/ready transfer, then reports the wall-cell count.
module maze_scanner
  import maze_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  maze_scanner_if.master bus
);

  state_e                   state_q, state_d;
  logic [MAZE_W*MAZE_H-1:0] snap_q, snap_d;
  logic [COORD_W-1:0]       x_q, x_d, y_q, y_d;
  logic [COORD_W-1:0]       x_last_q, x_last_d, y_last_q, y_last_d;
  logic [COUNT_W-1:0]       count_q, count_d;
  logic [COUNT_W-1:0]       wall_count_q, wall_count_d;

  logic [IDX_W-1:0]         idx_s;
  logic                     cur_wall_s;
  logic                     last_s;
  logic                     streaming_s;

  // Cell lookup: bit x + MAZE_W*y of the snapshot, never overflows 12 bits.
  assign idx_s       = IDX_W'(x_q) + IDX_W'(MAZE_W) * IDX_W'(y_q);
  assign cur_wall_s  = snap_q[idx_s +: 1];
  assign last_s      = (x_q == x_last_q) && (y_q == y_last_q);
  assign streaming_s = (state_q == ST_STREAM);

  // Next-state logic for the FSM, counters, snapshot and result register.
  always_comb begin
    state_d      = state_q;
    snap_d       = snap_q;
    x_d          = x_q;
    y_d          = y_q;
    x_last_d     = x_last_q;
    y_last_d     = y_last_q;
    count_d      = count_q;
    wall_count_d = wall_count_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.maze_finish) begin
          snap_d   = bus.maze_data;
          x_last_d = COORD_W'(active_extent(bus.x_dimension) - 7'd1);
          y_last_d = COORD_W'(active_extent(bus.y_dimension) - 7'd1);
          x_d      = '0;
          y_d      = '0;
          count_d  = '0;
          state_d  = ST_STREAM;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (bus.cell_ready) begin
          count_d = count_q + COUNT_W'(cur_wall_s);
          if (last_s) begin
            state_d = ST_DONE;
          end else if (x_q == x_last_q) begin
            x_d = '0;
            y_d = y_q + 6'd1;
          end else begin
            x_d = x_q + 6'd1;
          end
        end else begin
          state_d = ST_STREAM;
        end
      end
      ST_DONE: begin
        // count_q already includes the final cell's bit.
        wall_count_d = count_q;
        state_d      = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      snap_q       <= '0;
      x_q          <= '0;
      y_q          <= '0;
      x_last_q     <= '0;
      y_last_q     <= '0;
      count_q      <= '0;
      wall_count_q <= '0;
    end else begin
      state_q      <= state_d;
      snap_q       <= snap_d;
      x_q          <= x_d;
      y_q          <= y_d;
      x_last_q     <= x_last_d;
      y_last_q     <= y_last_d;
      count_q      <= count_d;
      wall_count_q <= wall_count_d;
    end
  end

  // Wall and last flags are qualified so they never linger outside STREAM.
  assign bus.cell_valid = streaming_s;
  assign bus.cell_wall  = streaming_s & cur_wall_s;
  assign bus.cell_last  = streaming_s & last_s;
  assign bus.cell_x     = x_q;
  assign bus.cell_y     = y_q;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.scan_done  = (state_q == ST_DONE);
  assign bus.wall_count = wall_count_q;

endmodule

// File: tb/tb_maze_scanner.sv
// Directed bench for maze_scanner: reference bitmap model, per-cell checks.
module tb_maze_scanner;
  import maze_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [MAZE_W*MAZE_H-1:0] ref_maze;

  maze_scanner_if bus ();

  maze_scanner dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one scan from a negedge in IDLE and returns at a negedge in IDLE.
  task automatic run_scan(input int xd, input int yd, input bit rnd, input bit perturb,
                          input int abort_at, input bit b2b, input int exp_walls);
    int   w, h, ex, ey, n, budget;
    bit   rdy;
    logic [14:0] obs, exp;
    w = 8 * (xd + 1);
    h = 8 * (yd + 1);
    ex = 0; ey = 0; n = 0;
    bus.maze_data   = ref_maze;
    bus.x_dimension = xd[2:0];
    bus.y_dimension = yd[2:0];
    bus.cell_ready  = 1'b0;
    bus.maze_finish = 1'b1;
    chk("idle_before_capture", {31'd0, bus.cell_valid}, 32'd0);
    @(posedge clk); @(negedge clk);
    bus.maze_finish = 1'b0;
    chk("first_valid_latency", {30'd0, bus.cell_valid, bus.busy}, 32'd3);
    budget = 4 * w * h + 20;
    while (n < w * h && budget > 0) begin
      budget--;
      exp = {1'b1, ex[5:0], ey[5:0], ref_maze[ex + 64 * ey], (ex == w - 1 && ey == h - 1)};
      obs = {bus.cell_valid, bus.cell_x, bus.cell_y, bus.cell_wall, bus.cell_last};
      chk("cell", {17'd0, obs}, {17'd0, exp});
      if (n == abort_at) begin
        reset = 1'b1;
        #1;
        chk("abort_outputs", {29'd0, bus.cell_valid, bus.busy, bus.scan_done}, 32'd0);
        chk("abort_wall_count", {19'd0, bus.wall_count}, 32'd0);
        @(negedge clk);
        chk("abort_no_done", {31'd0, bus.scan_done}, 32'd0);
        reset = 1'b0;
        bus.cell_ready = 1'b0;
        return;
      end
      if (perturb && n == 37) begin
        bus.maze_data   = '0;
        bus.x_dimension = 3'd0;
        bus.maze_finish = 1'b1;
      end
      if (perturb && n == 38) bus.maze_finish = 1'b0;
      rdy = rnd ? bit'($urandom_range(0, 1)) : 1'b1;
      bus.cell_ready = rdy;
      @(posedge clk); @(negedge clk);
      if (rdy) begin
        n++;
        if (ex == w - 1) begin ex = 0; ey++; end else ex++;
      end
    end
    if (budget == 0) chk("scan_timeout", n, w * h);
    bus.cell_ready  = 1'b0;
    bus.maze_finish = b2b;
    chk("done_cycle", {28'd0, bus.scan_done, bus.cell_valid, bus.busy, bus.cell_last}, 32'hA);
    @(posedge clk); @(negedge clk);
    chk("after_done", {29'd0, bus.scan_done, bus.busy, bus.cell_valid}, 32'd0);
    chk("wall_count", {19'd0, bus.wall_count}, exp_walls);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.maze_finish = 1'b0;
    bus.maze_data   = '0;
    bus.x_dimension = 3'd0;
    bus.y_dimension = 3'd0;
    bus.cell_ready  = 1'b0;
    #1;
    chk("reset_outputs", {17'd0, bus.cell_valid, bus.cell_wall, bus.cell_x, bus.cell_y,
                          bus.cell_last, bus.busy, bus.scan_done}, 32'd0);
    chk("reset_wall_count", {19'd0, bus.wall_count}, 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", {30'd0, bus.busy, bus.cell_valid}, 32'd0);

    // All walls, smallest region.
    ref_maze = '1;
    run_scan(0, 0, 1'b0, 1'b0, -1, 1'b0, 64);

    // Checkerboard, full 64x64, followed immediately by the next scan.
    for (int i = 0; i < MAZE_W * MAZE_H; i++) ref_maze[i] = ((i % 64) + (i / 64)) % 2 == 1;
    run_scan(7, 7, 1'b0, 1'b0, -1, 1'b1, 2048);

    // Single wall at (15,3) inside a 16x8 region.
    ref_maze = '0;
    ref_maze[64 * 3 + 15] = 1'b1;
    run_scan(1, 0, 1'b0, 1'b0, -1, 1'b0, 1);

    // Checkerboard 32x32 with random back-pressure.
    for (int i = 0; i < MAZE_W * MAZE_H; i++) ref_maze[i] = ((i % 64) + (i / 64)) % 2 == 1;
    run_scan(3, 3, 1'b1, 1'b0, -1, 1'b0, 512);

    // Input churn mid-scan must not disturb the snapshot.
    run_scan(1, 1, 1'b0, 1'b1, -1, 1'b0, 128);

    // Reset at cell (5,2) aborts the scan and clears the result.
    ref_maze = '1;
    run_scan(0, 0, 1'b0, 1'b0, 21, 1'b0, 0);
    @(negedge clk);
    chk("post_abort_idle", {29'd0, bus.busy, bus.scan_done, bus.cell_valid}, 32'd0);

    // Fresh scan after the abort restarts from (0,0).
    run_scan(0, 0, 1'b0, 1'b0, -1, 1'b0, 64);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
